keypad_hex_reader: RTL
======================

# keypad_hex_reader

Scans a 4x4 hexadecimal matrix keypad on the board's Pmod header, debounces presses, and turns each accepted keypress into a 4-bit hex code. It also keeps a shift-accumulated entry value. It is the input-side counterpart of the multiplexed seven-segment output path: it strobes columns the way the display strobes digit enables, and reads rows back. `Number` is sized to feed the display's two 16-bit halves directly, so the processor top level can show typed values.

## Interface
Parameters:
- `SCAN_DIV_W`, 16: width of the scan-slot counter; one column slot lasts 2^`SCAN_DIV_W` Clk cycles (~655 µs at 100 MHz).
- `DEBOUNCE_SAMPLES`, 4: number of consecutive matching sample ticks needed to accept a press or a release; must be ≥1.
- `NUM_WIDTH`, 32: width of the accumulated entry register; must be a multiple of 4.

Ports:
- `Clk`, in, 1: system clock.
- `Reset`, in, 1: synchronous, active-high.
- `row_in`, in, 4: keypad rows, active-low, externally pulled up.
- `clear_in`, in, 1: synchronous clear of `Number`.
- `col_out`, out, 4: column strobes, active-low, exactly one low at all times.
- `key_code`, out, 4: hex code of the last accepted key; holds its value between presses.
- `key_valid`, out, 1: one-cycle pulse when a press is accepted.
- `Number`, out, `NUM_WIDTH`: entry register, updated by shift-left-by-4 with `key_code` inserted in the low nibble.

## Operation
- Slot counter `scnt` (`SCAN_DIV_W` bits) free-runs. The sample tick `stick` is asserted on the cycle where `scnt` is all ones. Sampling at the end of the slot gives the rows the whole slot to settle.
- Column index `col` (2 bits) drives `col_out = ~(4'b0001 << col)`. It advances on `stick` only in state SCAN, and wraps 3→0.
- Row decode: any row low means pressed. If several rows are low, the lowest row index wins.
- Key map, written as row r / col 0..3:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- FSM states and transitions:
  - SCAN: on `stick` with a row low, latch `{col,row}` into `cand`, set `stable` to 1, go to DEBOUNCE. The column does not advance on that tick.
  - DEBOUNCE: the column is frozen. On `stick`, if the same row is low, increment `stable`. When `stable` reaches `DEBOUNCE_SAMPLES`, go to ACCEPT.
    - If on `stick` the latched row is high, or a different row is low, return to SCAN. The column advances on that tick.
    - With `DEBOUNCE_SAMPLES`=1, go straight from SCAN to ACCEPT.
  - ACCEPT: lasts one cycle. `key_code` takes the mapped code, `key_valid` is 1, `Number` shifts. Go to HELD with `rel` = 0.
  - HELD: the column stays frozen. On `stick`, all rows high increments `rel`; any row low resets `rel` to 0. When `rel` reaches `DEBOUNCE_SAMPLES`, go to SCAN. A held key never repeats.
- `clear_in` has priority over an ACCEPT shift. If both happen in the same cycle, `Number` becomes 0; `key_valid` and `key_code` still update.
- Reset values:
  - state SCAN; `scnt`, `col`, `stable`, `rel` all 0
  - `col_out` = 4'b1110
  - `key_code` = 0, `key_valid` = 0, `Number` = 0
- Reset mid-operation aborts any debounce or hold. No `key_valid` is emitted.

## Timing
- Press latency, measured from the first `stick` that sees the row low: (`DEBOUNCE_SAMPLES`−1) further ticks, plus 1 cycle (ACCEPT) to `key_valid`. Add 2 cycles when the synchronizer macro is enabled.
- `key_valid` is high for exactly one cycle. `key_code` and `Number` become valid in the same cycle `key_valid` is high.
- Minimum time between accepted presses: 2·`DEBOUNCE_SAMPLES` slots.
- The oldest nibble falls off the top of `Number` with no saturation or flag.

## Configuration
- `KEYPAD_SYNC_EN`, when defined:
  - `row_in` passes through a two-flop synchronizer, reset to 4'b1111, before any use.
  - Adds 2 cycles of latency.
- When undefined, `row_in` is used directly.
  - Bench timing is then exact to the cycle.
  - Boards must then guarantee synchronous rows.

## Structure
- Shared package holds:
  - FSM state encoding (SCAN, DEBOUNCE, ACCEPT, HELD)
  - the 16-entry key-map constant
  - the `col_out` reset value
- One natural sub-module, `keypad_row_sync`: the optional synchronizer plus lowest-row priority encoder. Outputs are `any_low` and `row_idx`.

## Test plan
Bench parameters: `SCAN_DIV_W`=2, `DEBOUNCE_SAMPLES`=3, macro off.
- After reset, idle rows 4'b1111 for 64 cycles: `col_out` cycles 1110→1101→1011→0111 every 4 cycles; `key_valid` never pulses.
- Hold row1 low only while col2 is driven, then keep it low: `key_valid` pulses once, 9 cycles after the first sampling tick; `key_code`=6; `Number`=0x6.
- Press 1, 2, 3, A in turn, each held 3 ticks and released 3 ticks: `Number`=0x123A; exactly 4 `key_valid` pulses.
- Bounce: row low for 2 ticks, then high: no `key_valid`; scanning resumes at the next column.
- Rows 0 and 3 low together on col0: `key_code`=1. Hold for 50 ticks: a single pulse only.
- With `Number`=0x00000012, assert `clear_in` in the ACCEPT cycle of key 5: `Number`=0, `key_code`=5. Separately, assert `Reset` during DEBOUNCE: no pulse, and all outputs return to their reset values.

Source files
------------

// File: rtl/keypad_hex_reader_pkg.sv
// keypad_hex_reader_pkg: shared types and constants for the 4x4 hex keypad reader.
//   kp_state_e  - scanner FSM state encoding
//   key_pos_t   - latched {col,row} position of a candidate key
//   KEY_MAP     - 16-entry row/col to hex code table
//   COL_OUT_RST - column strobe value out of reset (column 0 driven low)
// Optional build macro KEYPAD_SYNC_EN (used by keypad_row_sync) adds a row synchronizer.
package keypad_hex_reader_pkg;

    localparam int unsigned ROW_W     = 4;
    localparam int unsigned COL_IDX_W = 2;
    localparam int unsigned ROW_IDX_W = 2;
    localparam int unsigned CODE_W    = 4;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_ACCEPT   = 2'd2,
        ST_HELD     = 2'd3
    } kp_state_e;

    typedef struct packed {
        logic [COL_IDX_W-1:0] col;
        logic [ROW_IDX_W-1:0] row;
    } key_pos_t;

    localparam logic [ROW_W-1:0] COL_OUT_RST = 4'b1110;

    // Indexed by {row, col}; entry 0 is row 0 / col 0.
    localparam logic [15:0][CODE_W-1:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,   // row 3
        4'hC, 4'h9, 4'h8, 4'h7,   // row 2
        4'hB, 4'h6, 4'h5, 4'h4,   // row 1
        4'hA, 4'h3, 4'h2, 4'h1    // row 0
    };

    function automatic logic [CODE_W-1:0] key_lookup(input key_pos_t pos);
        return KEY_MAP[{pos.row, pos.col}];
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// keypad_row_sync: optional two-flop row synchronizer plus lowest-row priority encoder.
//   clk, rst  - present only when KEYPAD_SYNC_EN is defined (sync reset, active high)
//   row_in    - raw active-low keypad rows
//   any_low   - at least one row is pulled low
//   row_idx   - index of the lowest-numbered low row (0 when none)
// KEYPAD_SYNC_EN defined: rows pass through two flops reset to all ones (2 cycles latency).
// KEYPAD_SYNC_EN undefined: rows are used as-is and must already be synchronous.
module keypad_row_sync
    import keypad_hex_reader_pkg::*;
(
`ifdef KEYPAD_SYNC_EN
    input  logic                 clk,
    input  logic                 rst,
`endif
    input  logic [ROW_W-1:0]     row_in,
    output logic                 any_low,
    output logic [ROW_IDX_W-1:0] row_idx
);

    logic [ROW_W-1:0] rows;

`ifdef KEYPAD_SYNC_EN
    logic [ROW_W-1:0] meta_q, meta_d;
    logic [ROW_W-1:0] sync_q, sync_d;

    // Synchronizer next values.
    always_comb begin
        meta_d = row_in;
        sync_d = meta_q;
    end

    // Synchronizer flops idle at "no key pressed".
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign rows = sync_q;
`else
    assign rows = row_in;
`endif

    // Lowest row index wins when several rows are low.
    always_comb begin
        any_low = ~&rows;
        row_idx = 2'd0;
        casez (rows)
            4'b???0: row_idx = 2'd0;
            4'b??01: row_idx = 2'd1;
            4'b?011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
    end

endmodule

// File: rtl/keypad_hex_reader.sv
// keypad_hex_reader: scans a 4x4 hex keypad, debounces presses and accumulates typed nibbles.
//   Clk, Reset  - clock, synchronous active-high reset
//   row_in      - keypad rows, active low
//   clear_in    - synchronous clear of Number (wins over a same-cycle shift)
//   col_out     - column strobes, active low, exactly one low
//   key_code    - hex code of the last accepted key
//   key_valid   - one-cycle pulse per accepted press
//   Number      - entry register, shifted left by 4 with key_code in the low nibble
// Build macro KEYPAD_SYNC_EN: synchronize row_in before use (adds 2 cycles).
module keypad_hex_reader
    import keypad_hex_reader_pkg::*;
#(
    parameter int unsigned SCAN_DIV_W       = 16,
    parameter int unsigned DEBOUNCE_SAMPLES = 4,
    parameter int unsigned NUM_WIDTH        = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [ROW_W-1:0]     row_in,
    input  logic                 clear_in,
    output logic [ROW_W-1:0]     col_out,
    output logic [CODE_W-1:0]    key_code,
    output logic                 key_valid,
    output logic [NUM_WIDTH-1:0] Number
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SAMPLES);

    kp_state_e               state_q, state_d;
    logic [SCAN_DIV_W-1:0]   scnt_q, scnt_d;
    logic [COL_IDX_W-1:0]    col_q, col_d;
    key_pos_t                cand_q, cand_d;
    logic [CNT_W-1:0]        stable_q, stable_d;
    logic [CNT_W-1:0]        rel_q, rel_d;
    logic [ROW_W-1:0]        col_out_q, col_out_d;
    logic [CODE_W-1:0]       key_code_q, key_code_d;
    logic                    key_valid_q, key_valid_d;
    logic [NUM_WIDTH-1:0]    number_q, number_d;

    logic                    stick_c;
    logic                    accept_c;
    key_pos_t                accept_pos_c;
    logic                    any_low;
    logic [ROW_IDX_W-1:0]    row_idx;

    keypad_row_sync u_row_sync (
`ifdef KEYPAD_SYNC_EN
        .clk     (Clk),
        .rst     (Reset),
`endif
        .row_in  (row_in),
        .any_low (any_low),
        .row_idx (row_idx)
    );

    // Sample at the end of each slot so rows have the whole slot to settle.
    assign stick_c = &scnt_q;

    // Next-state, counters and accept-side outputs.
    always_comb begin
        state_d      = state_q;
        scnt_d       = scnt_q + SCAN_DIV_W'(1);
        col_d        = col_q;
        cand_d       = cand_q;
        stable_d     = stable_q;
        rel_d        = rel_q;
        key_code_d   = key_code_q;
        key_valid_d  = 1'b0;
        number_d     = number_q;
        accept_c     = 1'b0;
        accept_pos_c = cand_q;

        unique case (state_q)
            ST_SCAN: begin
                if (stick_c) begin
                    if (any_low) begin
                        cand_d   = '{col: col_q, row: row_idx};
                        stable_d = CNT_W'(1);
                        if (CNT_W'(1) == CNT_DONE) begin
                            accept_c     = 1'b1;
                            accept_pos_c = '{col: col_q, row: row_idx};
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                // A different (lower) row going low also counts as a bounce.
                if (stick_c) begin
                    if (any_low && (row_idx == cand_q.row)) begin
                        stable_d = stable_q + CNT_W'(1);
                        if ((stable_q + CNT_W'(1)) == CNT_DONE) begin
                            accept_c = 1'b1;
                        end
                    end else begin
                        state_d = ST_SCAN;
                        col_d   = col_q + 2'd1;
                    end
                end
            end
            ST_ACCEPT: begin
                state_d = ST_HELD;
                rel_d   = '0;
            end
            ST_HELD: begin
                // Wait for a debounced release; the column stays on the held key.
                if (stick_c) begin
                    if (any_low) begin
                        rel_d = '0;
                    end else begin
                        rel_d = rel_q + CNT_W'(1);
                        if ((rel_q + CNT_W'(1)) == CNT_DONE) begin
                            state_d = ST_SCAN;
                        end
                    end
                end
            end
            default: state_d = ST_SCAN;
        endcase

        // Outputs are loaded on the edge into ACCEPT so they are visible during ACCEPT.
        if (accept_c) begin
            state_d     = ST_ACCEPT;
            key_valid_d = 1'b1;
            key_code_d  = key_lookup(accept_pos_c);
            number_d    = (number_q << 4) | NUM_WIDTH'(key_code_d);
        end

        if (clear_in) begin
            number_d = '0;
        end

        col_out_d = ~(4'b0001 << col_d);
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_SCAN;
            scnt_q      <= '0;
            col_q       <= '0;
            cand_q      <= '0;
            stable_q    <= '0;
            rel_q       <= '0;
            col_out_q   <= COL_OUT_RST;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            number_q    <= '0;
        end else begin
            state_q     <= state_d;
            scnt_q      <= scnt_d;
            col_q       <= col_d;
            cand_q      <= cand_d;
            stable_q    <= stable_d;
            rel_q       <= rel_d;
            col_out_q   <= col_out_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            number_q    <= number_d;
        end
    end

    assign col_out   = col_out_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign Number    = number_q;

endmodule
